// File: rtl/iomem_wb_pkg.sv
// iomem_wb_pkg: shared FSM state type and constants for the iomem-to-Wishbone bridge
package iomem_wb_pkg;
  localparam int MAX_SLAVES = 8;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/iomem_wb_decoder.sv
// iomem_wb_decoder: maps an address tag to a slave channel; lowest matching index wins
//   tag  in   8          address bits [31:24]
//   hit  out  1          some slot matched
//   sel  out  NUM_SLAVES one-hot of the winning slot (0 on miss)
//   idx  out  IW         index of the winning slot (0 on miss)
module iomem_wb_decoder import iomem_wb_pkg::*; #(
  parameter int NUM_SLAVES = 2,
  parameter logic [8*NUM_SLAVES-1:0] SLAVE_BASE = '0,
  parameter int IW = idx_w(NUM_SLAVES)
) (
  input  logic [7:0]            tag,
  output logic                  hit,
  output logic [NUM_SLAVES-1:0] sel,
  output logic [IW-1:0]         idx
);
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (SLAVE_BASE[8*i +: 8] == tag) begin
        hit = 1'b1;
        sel = '0;
        sel[i] = 1'b1;
        idx = IW'(i);
      end
  end
endmodule

// File: rtl/iomem_wb_bridge.sv
// iomem_wb_bridge: picosoc iomem port to NUM_SLAVES non-pipelined Wishbone masters
//   clk, resetn                      clock, async active-low reset
//   iomem_valid/ready/wstrb/addr/wdata/rdata   picosoc side; rdata is 0 unless ready
//   wbm_cyc_o/stb_o [NUM_SLAVES]     per-slave cycle/strobe (always equal, at most one set)
//   wbm_we_o/sel_o/adr_o/dat_o       shared registered request fields
//   wbm_dat_i [32*NUM_SLAVES], wbm_ack_i [NUM_SLAVES]   per-slave responses
//   timeout_o                        one-cycle pulse when a bus cycle is aborted
//   err_addr_o                       address of the last unmapped or timed-out access
module iomem_wb_bridge import iomem_wb_pkg::*; #(
  parameter int NUM_SLAVES = 2,
  parameter logic [8*NUM_SLAVES-1:0] SLAVE_BASE = {8'h30, 8'h03},
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     iomem_valid,
  output logic                     iomem_ready,
  input  logic [3:0]               iomem_wstrb,
  input  logic [31:0]              iomem_addr,
  input  logic [31:0]              iomem_wdata,
  output logic [31:0]              iomem_rdata,
  output logic [NUM_SLAVES-1:0]    wbm_cyc_o,
  output logic [NUM_SLAVES-1:0]    wbm_stb_o,
  output logic                     wbm_we_o,
  output logic [3:0]               wbm_sel_o,
  output logic [31:0]              wbm_adr_o,
  output logic [31:0]              wbm_dat_o,
  input  logic [32*NUM_SLAVES-1:0] wbm_dat_i,
  input  logic [NUM_SLAVES-1:0]    wbm_ack_i,
  output logic                     timeout_o,
  output logic [31:0]              err_addr_o
);
  localparam int IW = idx_w(NUM_SLAVES);
  localparam int CW = TIMEOUT_CYCLES < 1 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  state_t state, next;
  logic hit, ack, tmo;
  logic [NUM_SLAVES-1:0] dec_sel, cyc;
  logic [IW-1:0] dec_idx, idx;
  logic [CW-1:0] cnt;
  iomem_wb_decoder #(.NUM_SLAVES(NUM_SLAVES), .SLAVE_BASE(SLAVE_BASE), .IW(IW)) u_dec (
    .tag(iomem_addr[31:24]),
    .hit(hit),
    .sel(dec_sel),
    .idx(dec_idx)
  );
  assign wbm_cyc_o = cyc;
  assign wbm_stb_o = cyc;
  // cnt counts completed stb cycles, so the last permitted cycle sees TIMEOUT_CYCLES-1
  always_comb begin
    ack = wbm_ack_i[idx];
    tmo = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
    next = state == IDLE   ? (iomem_valid ? (hit ? ACCESS : DONE) : IDLE) :
           state == ACCESS ? ((ack || tmo) ? DONE : ACCESS) : IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cyc <= '0;
      idx <= '0;
      cnt <= '0;
      wbm_we_o <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      timeout_o <= 1'b0;
      err_addr_o <= '0;
    end else begin
      state <= next;
      iomem_ready <= next == DONE;
      iomem_rdata <= '0;
      timeout_o <= state == ACCESS && !ack && tmo;
      if (state == IDLE && iomem_valid) begin
        wbm_adr_o <= iomem_addr;
        wbm_dat_o <= iomem_wdata;
        wbm_sel_o <= iomem_wstrb;
        wbm_we_o <= |iomem_wstrb;
        idx <= dec_idx;
        cyc <= dec_sel;
        cnt <= '0;
        if (!hit) begin
          iomem_rdata <= ERR_DATA;
          err_addr_o <= iomem_addr;
        end
      end
      if (state == ACCESS) begin
        cnt <= &cnt ? cnt : cnt + 1'b1;
        if (ack || tmo) cyc <= '0;
        if (ack) iomem_rdata <= wbm_we_o ? '0 : wbm_dat_i[32*idx +: 32];
        else if (tmo) begin
          iomem_rdata <= ERR_DATA;
          err_addr_o <= wbm_adr_o;
        end
      end
    end
  end
endmodule

// File: tb/tb_iomem_wb_bridge.sv
// tb_iomem_wb_bridge: directed self-checking bench for iomem_wb_bridge
module tb_iomem_wb_bridge;
  logic clk = 1'b0;
  logic resetn;
  logic iomem_valid, iomem_ready, timeout_o;
  logic [3:0] iomem_wstrb, wbm_sel_o;
  logic [31:0] iomem_addr, iomem_wdata, iomem_rdata, wbm_adr_o, wbm_dat_o, err_addr_o;
  logic [1:0] wbm_cyc_o, wbm_stb_o, wbm_ack_i, force_ack;
  logic wbm_we_o;
  logic [31:0] rd0, rd1;
  logic [63:0] wbm_dat_i;
  int delay [2];
  int scnt [2];
  int checks = 0, errors = 0, bad = 0;
  int n, c0, c1, k;
  logic [31:0] rd, s_adr, s_dat;
  logic [3:0] s_sel;
  logic s_we, to;

  iomem_wb_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .timeout_o(timeout_o), .err_addr_o(err_addr_o)
  );

  always #5 clk = ~clk;

  // slave models: slave s acks in its delay[s]-th stb cycle (0 = never), plus a forced ack
  assign wbm_dat_i = {rd1, rd0};
  always @(posedge clk)
    for (int s = 0; s < 2; s++) scnt[s] <= wbm_cyc_o[s] ? scnt[s] + 1 : 0;
  always_comb begin
    wbm_ack_i = force_ack;
    for (int s = 0; s < 2; s++)
      if (wbm_cyc_o[s] && delay[s] != 0 && scnt[s] == delay[s] - 1) wbm_ack_i[s] = 1'b1;
  end

  // bus rules that must hold on every cycle
  always @(negedge clk)
    if (wbm_cyc_o != wbm_stb_o || $countones(wbm_cyc_o) > 1 || (!iomem_ready && iomem_rdata != 0))
      bad++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // n counts the cycles valid is held, including the accept cycle and the ready cycle;
  // request inputs are scrambled after acceptance to show they are no longer used
  task automatic xact(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    iomem_addr = a; iomem_wdata = w; iomem_wstrb = s; iomem_valid = 1'b1;
    n = 1; c0 = 0; c1 = 0;
    while (!iomem_ready && n < 50) begin
      @(negedge clk);
      n++;
      c0 += int'(wbm_cyc_o[0]);
      c1 += int'(wbm_cyc_o[1]);
      if (|wbm_cyc_o) begin
        s_adr = wbm_adr_o; s_dat = wbm_dat_o; s_sel = wbm_sel_o; s_we = wbm_we_o;
      end
      iomem_addr = ~a; iomem_wdata = ~w; iomem_wstrb = ~s;
    end
    chk("xact_bound", 32'(n < 50), 1);
    rd = iomem_rdata;
    to = timeout_o;
    iomem_valid = 1'b0;
    @(negedge clk);
    chk("ready_pulse", 32'(iomem_ready), 0);
    chk("timeout_pulse", 32'(timeout_o), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = '0; iomem_addr = '0; iomem_wdata = '0;
    force_ack = '0; rd0 = '0; rd1 = 32'h5A5A_0002; delay[0] = 0; delay[1] = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(iomem_ready), 0);
    chk("rst_rdata", iomem_rdata, 0);
    chk("rst_cyc", 32'(wbm_cyc_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_err_addr", err_addr_o, 0);
    chk("rst_adr", wbm_adr_o, 0);
    resetn = 1'b1;
    @(negedge clk);

    delay[1] = 2;
    xact(32'h3000_0010, 32'h1234_5678, 4'hF);
    chk("wr_latency", n, 4);
    chk("wr_we", 32'(s_we), 1);
    chk("wr_sel", 32'(s_sel), 32'hF);
    chk("wr_adr", s_adr, 32'h3000_0010);
    chk("wr_dat", s_dat, 32'h1234_5678);
    chk("wr_rdata", rd, 0);
    chk("wr_c1", c1, 2);
    chk("wr_c0", c0, 0);

    delay[0] = 1; rd0 = 32'hA5A5_0001;
    xact(32'h0300_0000, 32'h0, 4'h0);
    chk("rd_latency", n, 3);
    chk("rd_rdata", rd, 32'hA5A5_0001);
    chk("rd_we", 32'(s_we), 0);
    chk("rd_c1", c1, 0);
    chk("rd_c0", c0, 1);

    xact(32'h4000_0000, 32'h0, 4'h0);
    chk("miss_latency", n, 2);
    chk("miss_rdata", rd, 32'hDEAD_BEEF);
    chk("miss_err_addr", err_addr_o, 32'h4000_0000);
    chk("miss_timeout", 32'(to), 0);
    chk("miss_cyc", c0 + c1, 0);

    delay[0] = 0;
    xact(32'h0300_0004, 32'h0, 4'h0);
    chk("to_latency", n, 6);
    chk("to_c0", c0, 4);
    chk("to_rdata", rd, 32'hDEAD_BEEF);
    chk("to_pulse", 32'(to), 1);
    chk("to_err_addr", err_addr_o, 32'h0300_0004);

    delay[0] = 4; rd0 = 32'h0BAD_F00D;
    xact(32'h0300_000C, 32'h0, 4'h0);
    chk("ack4_latency", n, 6);
    chk("ack4_rdata", rd, 32'h0BAD_F00D);
    chk("ack4_timeout", 32'(to), 0);
    chk("ack4_err_addr", err_addr_o, 32'h0300_0004);

    delay[0] = 3; rd0 = 32'h1111_2222; force_ack = 2'b10;
    xact(32'h0300_0020, 32'h0, 4'h0);
    chk("other_ack_latency", n, 5);
    chk("other_ack_rdata", rd, 32'h1111_2222);
    force_ack = '0;

    delay[0] = 0;
    iomem_addr = 32'h0300_0008; iomem_wstrb = 4'h0; iomem_valid = 1'b1;
    @(negedge clk);
    chk("ra_cyc_before", 32'(wbm_cyc_o), 1);
    iomem_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("ra_cyc_async", 32'(wbm_cyc_o), 0);
    chk("ra_stb_async", 32'(wbm_stb_o), 0);
    chk("ra_adr_async", wbm_adr_o, 0);
    k = 0;
    repeat (3) begin
      @(negedge clk);
      k += int'(iomem_ready);
    end
    chk("ra_no_ready", k, 0);
    resetn = 1'b1;
    @(negedge clk);
    delay[0] = 1; rd0 = 32'h7777_6666;
    xact(32'h0300_0010, 32'h0, 4'h0);
    chk("ra_after_latency", n, 3);
    chk("ra_after_rdata", rd, 32'h7777_6666);

    chk("bus_rules", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
